// File: rtl/msriscv32_pkg.sv
// Shared AHB constants and fetch-path types for the msriscv32_mp core.
package msriscv32_pkg;

    localparam int FQ_XLEN = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [FQ_XLEN-1:0] instr;
        logic [FQ_XLEN-1:0] pc;
        logic               fault;
    } fq_entry_t;

endpackage

// File: rtl/msriscv32_sync_fifo.sv
// Synchronous FIFO with power-of-two depth, wrapping pointers and a clear that
// has priority over push and pop.
module msriscv32_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        data_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        data_o,
    output logic                    empty_o,
    output logic                    full_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q;
    logic [PW-1:0]    rdPtr_q;
    logic [PW:0]      count_q;
    logic             doPush;
    logic             doPop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rdPtr_q];

    assign doPop  = pop_i && !empty_o;
    assign doPush = push_i && (!full_o || doPop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (clear_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + PW'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + PW'(1);
            if (doPush && !doPop)      count_q <= count_q + (PW+1)'(1);
            else if (doPop && !doPush) count_q <= count_q - (PW+1)'(1);
        end
    end

    // Storage needs no reset: entries are only read while the count says they are valid.
    always_ff @(posedge clk_i) begin
        if (doPush && !clear_i) mem_q[wrPtr_q] <= data_i;
    end

endmodule

// File: rtl/msriscv32_fetch_queue.sv
// Instruction prefetch queue: pipelined AHB-Lite word fetches buffered with their
// PCs ahead of decode, flushed and refetched on a redirect.
module msriscv32_fetch_queue
    import msriscv32_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            msriscv32_mp_clk_in,
    input  logic            msriscv32_mp_rst_in,
    input  logic            redirect_in,
    input  logic [XLEN-1:0] redirect_pc_in,
    output logic [XLEN-1:0] msriscv32_mp_imaddr_out,
    output logic [1:0]      msriscv32_mp_instr_htrans_out,
    input  logic [XLEN-1:0] msriscv32_mp_instr_in,
    input  logic            msriscv32_mp_instr_hready_in,
    input  logic            msriscv32_mp_instr_hresp_in,
    output logic            instr_valid_out,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] instr_pc_out,
    output logic            instr_fault_out,
    input  logic            instr_ready_in
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetchPc_q, fetchPc_d;
    logic [XLEN-1:0] redirectPc_q, redirectPc_d;
    logic [XLEN-1:0] dphasePc_q, dphasePc_d;
    logic            dphaseValid_q, dphaseValid_d;
    logic            dphaseDiscard_q, dphaseDiscard_d;
    logic            redirectPending_q, redirectPending_d;
    logic            addrHeld_q, addrHeld_d;

    logic            hready;
    logic            pop;
    logic            push;
    logic            busError;
    logic            issue;
    logic            nonseq;
    logic            accept;
    logic            redirectNow;
    logic [XLEN-1:0] alignedRedirectPc;
    logic [XLEN-1:0] targetPc;
    logic [CW:0]     occupancy;
    logic            fifoEmpty;
    logic            fifoFull;
    logic [CW-1:0]   fifoCount;
    fq_entry_t       pushEntry;
    fq_entry_t       headEntry;

    assign hready            = msriscv32_mp_instr_hready_in;
    assign alignedRedirectPc = redirect_pc_in & ~XLEN'(3);
    assign pop               = !fifoEmpty && instr_ready_in;
    assign push              = dphaseValid_q && hready && !dphaseDiscard_q;
    assign busError          = push && msriscv32_mp_instr_hresp_in;
    assign redirectNow       = redirect_in || redirectPending_q;
    assign targetPc          = redirect_in ? alignedRedirectPc : redirectPc_q;

    // Reserve a slot for every beat in flight so a returning beat always fits.
    assign occupancy = {1'b0, fifoCount} + (CW+1)'(dphaseValid_q) - (CW+1)'(pop);
    assign issue     = msriscv32_mp_rst_in && (state_q == RUN) && !redirect_in &&
                       !redirectPending_q && (occupancy < (CW+1)'(DEPTH));
    assign nonseq    = addrHeld_q || issue;
    assign accept    = nonseq && hready;

    always_comb begin
        pushEntry.instr = msriscv32_mp_instr_hresp_in ? '0 : msriscv32_mp_instr_in;
        pushEntry.pc    = dphasePc_q;
        pushEntry.fault = msriscv32_mp_instr_hresp_in;
    end

    // A redirect seen in a wait state is parked until the held address phase completes.
    always_comb begin
        state_d           = state_q;
        fetchPc_d         = fetchPc_q;
        redirectPc_d      = redirectPc_q;
        redirectPending_d = redirectPending_q;
        dphaseValid_d     = dphaseValid_q;
        dphasePc_d        = dphasePc_q;
        dphaseDiscard_d   = dphaseDiscard_q;
        addrHeld_d        = nonseq && !hready;

        if (redirect_in)   state_d = RUN;
        else if (busError) state_d = HALT;

        if (hready) begin
            redirectPending_d = 1'b0;
            dphaseValid_d     = accept;
            dphasePc_d        = fetchPc_q;
            dphaseDiscard_d   = accept && (redirectNow || busError);
            if (redirectNow)  fetchPc_d = targetPc;
            else if (accept)  fetchPc_d = fetchPc_q + XLEN'(4);
        end else if (redirect_in) begin
            redirectPending_d = 1'b1;
            redirectPc_d      = alignedRedirectPc;
            dphaseDiscard_d   = 1'b1;
        end
    end

    always_ff @(posedge msriscv32_mp_clk_in or negedge msriscv32_mp_rst_in) begin
        if (!msriscv32_mp_rst_in) begin
            state_q           <= RUN;
            fetchPc_q         <= RESET_PC;
            redirectPc_q      <= '0;
            redirectPending_q <= 1'b0;
            dphaseValid_q     <= 1'b0;
            dphasePc_q        <= '0;
            dphaseDiscard_q   <= 1'b0;
            addrHeld_q        <= 1'b0;
        end else begin
            state_q           <= state_d;
            fetchPc_q         <= fetchPc_d;
            redirectPc_q      <= redirectPc_d;
            redirectPending_q <= redirectPending_d;
            dphaseValid_q     <= dphaseValid_d;
            dphasePc_q        <= dphasePc_d;
            dphaseDiscard_q   <= dphaseDiscard_d;
            addrHeld_q        <= addrHeld_d;
        end
    end

    msriscv32_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fq_entry_t))
    ) u_fifo (
        .clk_i   (msriscv32_mp_clk_in),
        .rst_ni  (msriscv32_mp_rst_in),
        .clear_i (redirect_in),
        .push_i  (push),
        .data_i  (pushEntry),
        .pop_i   (pop),
        .data_o  (headEntry),
        .empty_o (fifoEmpty),
        .full_o  (fifoFull),
        .count_o (fifoCount)
    );

    assign msriscv32_mp_imaddr_out       = fetchPc_q;
    assign msriscv32_mp_instr_htrans_out = nonseq ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign instr_valid_out               = !fifoEmpty;
    assign instr_out                     = fifoEmpty ? '0 : headEntry.instr;
    assign instr_pc_out                  = fifoEmpty ? '0 : headEntry.pc;
    assign instr_fault_out               = fifoEmpty ? 1'b0 : headEntry.fault;

    pushNeverFull: assert property (@(posedge msriscv32_mp_clk_in)
        disable iff (!msriscv32_mp_rst_in) !(push && fifoFull && !redirect_in));

endmodule

// File: tb/tb_msriscv32_fetch_queue.sv
// Directed bench for the fetch queue: an AHB memory model answers fetches with
// addr^KEY while a scoreboard monitor checks every instruction decode accepts.
module tb_msriscv32_fetch_queue;

   localparam logic [31:0] KEY      = 32'hA5A5_A5A5;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NONSEQ   = 32'd2;
   localparam logic [31:0] IDLE     = 32'd0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
   } expEntry_t;

   logic        clk;
   logic        rstN;
   logic        redirect;
   logic [31:0] redirectPc;
   logic [31:0] imaddr;
   logic [1:0]  htrans;
   logic [31:0] instrData;
   logic        hready;
   logic        hresp;
   logic        instrValid;
   logic [31:0] instrOut;
   logic [31:0] instrPc;
   logic        instrFault;
   logic        instrReady;

   expEntry_t   expQ[$];
   expEntry_t   cur;
   int          errors = 0;
   int          checks = 0;
   int          nonseqCount;

   logic        busValid;
   logic [31:0] busAddr;
   logic        takeAddr;
   logic [31:0] takeA;
   logic        hreadySeen;
   logic        errArm;
   logic [31:0] errAddr;

   msriscv32_fetch_queue #(
      .XLEN     (32),
      .DEPTH    (4),
      .RESET_PC (RESET_PC)
   ) dut (
      .msriscv32_mp_clk_in           (clk),
      .msriscv32_mp_rst_in           (rstN),
      .redirect_in                   (redirect),
      .redirect_pc_in                (redirectPc),
      .msriscv32_mp_imaddr_out       (imaddr),
      .msriscv32_mp_instr_htrans_out (htrans),
      .msriscv32_mp_instr_in         (instrData),
      .msriscv32_mp_instr_hready_in  (hready),
      .msriscv32_mp_instr_hresp_in   (hresp),
      .instr_valid_out               (instrValid),
      .instr_out                     (instrOut),
      .instr_pc_out                  (instrPc),
      .instr_fault_out               (instrFault),
      .instr_ready_in                (instrReady)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory model: an address phase seen with hready high becomes the data phase of the next cycle.
   initial begin
      busValid  = 1'b0;
      busAddr   = 32'h0;
      instrData = 32'hDEAD_BEEF;
      hresp     = 1'b0;
      forever begin
         @(negedge clk);
         hreadySeen = hready;
         takeAddr   = rstN && (htrans == 2'b10) && hready;
         takeA      = imaddr;
         @(posedge clk);
         #1;
         if (!rstN) begin
            busValid = 1'b0;
         end else if (hreadySeen) begin
            busValid = takeAddr;
            busAddr  = takeA;
         end
         instrData = busValid ? (busAddr ^ KEY) : 32'hDEAD_BEEF;
         hresp     = busValid && errArm && (busAddr == errAddr);
      end
   end

   // Scoreboard monitor: every instruction decode accepts must match the next expected entry.
   initial begin
      forever begin
         @(negedge clk);
         if (rstN && instrValid && instrReady && !redirect) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_pop: got pc %h, expected no instruction", instrPc);
            end else begin
               cur = expQ.pop_front();
               checkOutput("pop_pc", instrPc, cur.pc);
               checkOutput("pop_instr", instrOut, cur.instr);
               checkOutput("pop_fault", {31'b0, instrFault}, {31'b0, cur.fault});
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic rdy, input logic hrdy, input logic redir, input logic [31:0] rpc);
      instrReady = rdy;
      hready     = hrdy;
      redirect   = redir;
      redirectPc = rpc;
   endtask

   task automatic pushExp(input logic [31:0] pc, input logic fault);
      expEntry_t e;
      e.pc    = pc;
      e.fault = fault;
      e.instr = fault ? 32'h0 : (pc ^ KEY);
      expQ.push_back(e);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Asserts reset mid-flight, checks reset values and leftovers, then releases it so cycle 0 begins.
   task automatic resetDut(input logic rdy);
      applyStimulus(rdy, 1'b1, 1'b0, 32'h0);
      errArm = 1'b0;
      rstN   = 1'b0;
      @(negedge clk);
      checkOutput("rst_imaddr", imaddr, RESET_PC);
      checkOutput("rst_htrans", {30'b0, htrans}, IDLE);
      checkOutput("rst_valid", {31'b0, instrValid}, 32'd0);
      checkOutput("rst_instr", instrOut, 32'd0);
      checkOutput("rst_pc", instrPc, 32'd0);
      checkOutput("rst_fault", {31'b0, instrFault}, 32'd0);
      checkOutput("sb_drain", 32'(expQ.size()), 32'd0);
      expQ.delete();
      nextCycle();
      nextCycle();
      rstN = 1'b1;
   endtask

   initial begin
      rstN    = 1'b0;
      errArm  = 1'b0;
      errAddr = 32'h0;
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      nextCycle();

      $display("[TB] streaming fetch with hready=1, ready=1");
      resetDut(1'b1);
      for (int j = 0; j < 8; j++) pushExp(32'(j * 4), 1'b0);
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
         @(negedge clk);
         checkOutput("s1_addr", imaddr, 32'(k * 4));
         checkOutput("s1_htrans", {30'b0, htrans}, NONSEQ);
         if (k == 1) checkOutput("s1_valid_c1", {31'b0, instrValid}, 32'd0);
         nextCycle();
      end

      $display("[TB] decode stalled for 10 cycles");
      resetDut(1'b0);
      for (int j = 0; j < 6; j++) pushExp(32'(j * 4), 1'b0);
      nonseqCount = 0;
      for (int k = 0; k < 16; k++) begin
         applyStimulus(k >= 10, 1'b1, 1'b0, 32'h0);
         @(negedge clk);
         if (htrans == 2'b10 && k < 10) nonseqCount++;
         if (k < 4) checkOutput("s2_addr", imaddr, 32'(k * 4));
         if (k == 9) checkOutput("s2_nonseq_count", 32'(nonseqCount), 32'd4);
         if (k == 10 || k == 11) begin
            checkOutput("s2_resume_addr", imaddr, 32'(16 + (k - 10) * 4));
            checkOutput("s2_resume_htrans", {30'b0, htrans}, NONSEQ);
         end
         nextCycle();
      end

      $display("[TB] redirect with three entries queued and a beat outstanding");
      resetDut(1'b0);
      pushExp(32'h100, 1'b0);
      pushExp(32'h104, 1'b0);
      pushExp(32'h108, 1'b0);
      for (int k = 0; k < 10; k++) begin
         applyStimulus(k >= 5, 1'b1, k == 4, 32'h100);
         @(negedge clk);
         if (k == 4) begin
            checkOutput("s3_valid_before", {31'b0, instrValid}, 32'd1);
            checkOutput("s3_head_before", instrPc, 32'h0);
         end
         if (k == 5) begin
            checkOutput("s3_valid_drop", {31'b0, instrValid}, 32'd0);
            checkOutput("s3_addr", imaddr, 32'h100);
            checkOutput("s3_htrans", {30'b0, htrans}, NONSEQ);
         end
         if (k == 6) checkOutput("s3_addr_next", imaddr, 32'h104);
         nextCycle();
      end

      $display("[TB] redirect during a three-cycle wait state");
      resetDut(1'b1);
      pushExp(32'h0, 1'b0);
      pushExp(32'h200, 1'b0);
      pushExp(32'h204, 1'b0);
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b1, !(k >= 2 && k <= 4), k == 3, 32'h200);
         @(negedge clk);
         if (k >= 2 && k <= 5) begin
            checkOutput("s4_held_addr", imaddr, 32'h8);
            checkOutput("s4_held_htrans", {30'b0, htrans}, NONSEQ);
         end
         if (k == 6) begin
            checkOutput("s4_redirect_addr", imaddr, 32'h200);
            checkOutput("s4_redirect_htrans", {30'b0, htrans}, NONSEQ);
         end
         if (k == 7) checkOutput("s4_next_addr", imaddr, 32'h204);
         nextCycle();
      end

      $display("[TB] bus error on the fetch at 0x8");
      resetDut(1'b1);
      errAddr = 32'h8;
      errArm  = 1'b1;
      pushExp(32'h0, 1'b0);
      pushExp(32'h4, 1'b0);
      pushExp(32'h8, 1'b1);
      pushExp(32'h300, 1'b0);
      pushExp(32'h304, 1'b0);
      for (int k = 0; k < 14; k++) begin
         applyStimulus(1'b1, 1'b1, k == 9, 32'h0000_0303);
         @(negedge clk);
         if (k >= 4 && k <= 9) checkOutput("s5_halt_htrans", {30'b0, htrans}, IDLE);
         if (k == 5) checkOutput("s5_no_entry_after_fault", {31'b0, instrValid}, 32'd0);
         if (k == 10) begin
            checkOutput("s5_resume_addr", imaddr, 32'h300);
            checkOutput("s5_resume_htrans", {30'b0, htrans}, NONSEQ);
         end
         nextCycle();
      end

      $display("[TB] fetch address wrap past 0xFFFFFFFC");
      resetDut(1'b1);
      pushExp(32'hFFFF_FFF8, 1'b0);
      pushExp(32'hFFFF_FFFC, 1'b0);
      pushExp(32'h0, 1'b0);
      pushExp(32'h4, 1'b0);
      for (int k = 0; k < 7; k++) begin
         applyStimulus(1'b1, 1'b1, k == 0, 32'hFFFF_FFF8);
         @(negedge clk);
         if (k == 1) checkOutput("s6_addr_fff8", imaddr, 32'hFFFF_FFF8);
         if (k == 2) checkOutput("s6_addr_fffc", imaddr, 32'hFFFF_FFFC);
         if (k == 3) begin
            checkOutput("s6_addr_wrap", imaddr, 32'h0);
            checkOutput("s6_htrans_wrap", {30'b0, htrans}, NONSEQ);
         end
         nextCycle();
      end

      resetDut(1'b1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
